morse_digit_player: RTL and testbench
=====================================

# morse_digit_player

Sequencer that turns the 8-nibble digit buffer produced by the keypad entry block into audible/visible Morse code. On a start pulse it snapshots the 32-bit buffer and plays each entered digit, oldest first, as a five-element Morse character on `tone`, driving a buzzer and LED. It is the transmit-side controller between the keypad buffer and the output drivers, and reports busy/done/error status to the top-level mode logic.

## Interface
- `UNIT_CYCLES`, default 10_000_000: clock cycles per Morse time unit (100 ms at 100 MHz); legal range ≥ 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `isAble`  in  1  block enable; low acts as a synchronous clear to idle.
- `start`  in  1  single-cycle request to play `digits`.
- `abort`  in  1  single-cycle request to stop playback immediately.
- `digits`  in  32  keypad buffer; nibble codes 0x1–0x9 = digits 1–9, 0xA = digit 0, 0x0 = empty; newest digit in [3:0].
- `tone`  out  1  high during a dot/dash mark.
- `busy`  out  1  high from the first mark until the end of playback.
- `done`  out  1  one-cycle pulse on normal completion.
- `cur_digit`  out  4  nibble code currently playing; 0 when idle.
- `bad_digit`  out  1  sticky: a nibble 0xB–0xF was skipped; cleared by the next accepted `start`.

## Operation
- States: IDLE, MARK, GAP, CHARGAP, FINISH.
- IDLE: `start` with `isAble`=1 snapshots `digits` into an internal register. Playback begins at the most-significant nonzero nibble and proceeds down to nibble [3:0]. Leading 0x0 nibbles are not played.
- All-zero `digits` at start: no tone; `busy` stays 0; `done` pulses once.
- Character encoding (5 elements, sent left to right):
  - digit n = 1..5: n dots, then 5−n dashes.
  - digit n = 6..9: n−5 dashes, then dots.
  - digit 0 (0xA): five dashes.
- Timing of elements:
  - MARK: `tone`=1 for 1 unit (dot) or 3 units (dash).
  - GAP: `tone`=0 for 1 unit between elements of the same character.
  - CHARGAP: `tone`=0 for 3 units between characters. This replaces the element gap; it is not added to it.
- Nibble handling during playback:
  - Embedded 0x0 nibbles are skipped silently and add no gap.
  - 0xB–0xF nibbles are skipped, add no gap, and set `bad_digit`.
  - If no playable nibble remains, the block behaves as the all-zero case. `bad_digit` still reflects any skipped invalid nibbles.
- After the last mark of the last playable character: FINISH for one cycle (`done`=1, `busy`=0, `tone`=0), then IDLE. No trailing gap.
- `start` while busy: ignored.
- `abort` or `isAble`=0 in any state: next cycle `tone`=0, `busy`=0, `cur_digit`=0, state IDLE, no `done`. `bad_digit` is cleared only by `isAble`=0 or `rst`.
- `start` and `abort` in the same IDLE cycle: `abort` wins, nothing plays.
- Changes on `digits` after the snapshot have no effect on the current playback.

## Timing
- Reset values: `tone`=0, `busy`=0, `done`=0, `cur_digit`=0, `bad_digit`=0, state IDLE, all counters 0.
- All outputs are registered.
- Latency: `start` sampled at edge k → `tone`, `busy`, `cur_digit` valid after edge k+1.
- Durations are exact: a dot is UNIT_CYCLES cycles of `tone`=1; a dash is 3×UNIT_CYCLES. Gaps are exact to the cycle.
- `cur_digit` updates on the first cycle of each character's first mark.
- Unit counter width: clog2(3×UNIT_CYCLES). The counter restarts at 0 on every state entry.

## Structure
- Package `morse_pkg` holds:
  - the state enum;
  - localparams `DOT_UNITS`=1, `DASH_UNITS`=3, `GAP_UNITS`=1, `CHARGAP_UNITS`=3;
  - function `digit_pattern(nibble)`, returning a 5-bit pattern (1 = dash, MSB first) and a valid flag.
- Sub-module `morse_unit_timer`: loadable down-counter producing an expiry pulse after N×UNIT_CYCLES cycles. It is cleared by abort, `!isAble`, or `rst`.
- Top level contains the FSM, the snapshot register, the nibble index (3 bits, 7→0), and the element index (0–4).

## Test plan
All scenarios use UNIT_CYCLES=4.
- `digits`=0x00000001, start → `tone` high 4, low 4, then 4× (high 12, low 4) minus the final low. Total 68 cycles from `tone` rise; `done` in the cycle after the last mark; `cur_digit`=1.
- `digits`=0x00000012 → '1' pattern, 12-cycle `tone`-low gap, then '2' (..---). `cur_digit` goes 1 then 2.
- `digits`=0x0000000A → five 12-cycle marks separated by 4-cycle gaps; `cur_digit`=0xA.
- `digits`=0 → `done` 1 cycle after start; `busy` and `tone` never assert.
- `digits`=0x000001F6 → plays '1', then '6' with a single 12-cycle gap between them; `bad_digit`=1 after playback; next start clears it.
- Mid-dash `abort` → `tone` and `busy` low next cycle, no `done`. A second `start` during playback is ignored; a new `start` after the abort replays from the first digit.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types, timing constants and digit helpers for the Morse digit player.
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_GAP,
    ST_CHARGAP,
    ST_FINISH
  } state_t;

  localparam int unsigned DOT_UNITS     = 1;
  localparam int unsigned DASH_UNITS    = 3;
  localparam int unsigned GAP_UNITS     = 1;
  localparam int unsigned CHARGAP_UNITS = 3;
  localparam int unsigned ELEMS         = 5;
  localparam int unsigned NIBS          = 8;

  // Element pattern of one character: bit 4 is sent first, 1 = dash.
  typedef struct packed {
    logic       valid;
    logic [4:0] pat;
  } pattern_t;

  // Result of searching the buffer for the next playable nibble.
  typedef struct packed {
    logic       found;
    logic [2:0] idx;
    logic       bad;
  } scan_t;

  // Map a keypad nibble code to its Morse element pattern.
  function automatic pattern_t digit_pattern(input logic [3:0] nib);
    pattern_t p;
    p.valid = 1'b1;
    p.pat   = 5'b00000;
    case (nib)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: p.pat = 5'b11111 >> nib;
      4'h6, 4'h7, 4'h8, 4'h9:       p.pat = ~(5'b11111 >> (nib - 4'd5));
      4'hA:                         p.pat = 5'b11111;
      default:                      p.valid = 1'b0;
    endcase
    return p;
  endfunction

  // Search nibbles first..0 for the highest playable one; flag invalid codes passed over.
  function automatic scan_t find_next(input logic [31:0] buf_i, input int first);
    scan_t      s;
    logic [3:0] nib;
    s = '0;
    for (int i = int'(NIBS) - 1; i >= 0; i--) begin
      nib = buf_i[4*i +: 4];
      if (i <= first && !s.found) begin
        if (digit_pattern(nib).valid) begin
          s.found = 1'b1;
          s.idx   = 3'(i);
        end else if (nib != 4'h0) begin
          s.bad = 1'b1;
        end
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Interval timer: after a load of N units, pulses expiry in the N*UNIT_CYCLES-th cycle.
module morse_unit_timer #(
  parameter int unsigned UNIT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic [1:0] i_units,
  output logic       o_expire_c
);

  localparam int unsigned CW = $clog2(3 * UNIT_CYCLES);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_target;
  logic          r_active;

  assign o_expire_c = r_active && (r_cnt == r_target);

  // Count from 0 up to the loaded terminal value, then go inactive unless reloaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_target <= '0;
      r_active <= 1'b0;
    end else if (i_clr) begin
      r_cnt    <= '0;
      r_target <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_cnt    <= '0;
      r_target <= CW'(32'(i_units) * UNIT_CYCLES - 32'd1);
      r_active <= 1'b1;
    end else if (r_active) begin
      if (o_expire_c) r_active <= 1'b0;
      else            r_cnt    <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/morse_digit_player.sv
// Plays the snapshotted keypad buffer, oldest digit first, as Morse code on tone.
module morse_digit_player
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        isAble,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] digits,
  output logic        tone,
  output logic        busy,
  output logic        done,
  output logic [3:0]  cur_digit,
  output logic        bad_digit
);

  state_t      r_state, w_nxt_state;
  logic [31:0] r_snap, w_nxt_snap;
  logic [2:0]  r_nib, w_nxt_nib;
  logic [2:0]  r_elem, w_nxt_elem;
  logic [4:0]  r_pat, w_nxt_pat;
  logic [3:0]  r_chr, w_nxt_chr;
  logic        r_bad, w_nxt_bad;

  logic        w_clr;
  logic        w_load;
  logic [1:0]  w_units;
  logic        w_expire;
  logic        w_playing;
  scan_t       w_scan_start, w_scan_next;
  logic [3:0]  w_start_nib, w_cur_nib;
  pattern_t    w_start_pat, w_next_pat;

  assign w_clr        = abort || !isAble;
  assign w_playing    = (r_state == ST_MARK) || (r_state == ST_GAP) || (r_state == ST_CHARGAP);
  assign w_scan_start = find_next(digits, int'(NIBS) - 1);
  assign w_scan_next  = find_next(r_snap, int'(r_nib) - 1);
  assign w_start_nib  = digits[{w_scan_start.idx, 2'b00} +: 4];
  assign w_start_pat  = digit_pattern(w_start_nib);
  assign w_next_pat   = digit_pattern(r_snap[{w_scan_next.idx, 2'b00} +: 4]);
  assign w_cur_nib    = r_snap[{r_nib, 2'b00} +: 4];
  assign bad_digit    = r_bad;

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_load    (w_load),
    .i_units   (w_units),
    .o_expire_c(w_expire)
  );

  // State and playback context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_snap  <= '0;
      r_nib   <= '0;
      r_elem  <= '0;
      r_pat   <= '0;
      r_chr   <= '0;
      r_bad   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_snap  <= w_nxt_snap;
      r_nib   <= w_nxt_nib;
      r_elem  <= w_nxt_elem;
      r_pat   <= w_nxt_pat;
      r_chr   <= w_nxt_chr;
      r_bad   <= w_nxt_bad;
    end
  end

  // Next-state logic; the timer is reloaded on every entry into a timed state.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_snap  = r_snap;
    w_nxt_nib   = r_nib;
    w_nxt_elem  = r_elem;
    w_nxt_pat   = r_pat;
    w_nxt_chr   = r_chr;
    w_nxt_bad   = r_bad;
    w_load      = 1'b0;
    w_units     = 2'(DOT_UNITS);
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nxt_snap = digits;
          w_nxt_bad  = w_scan_start.bad;
          if (w_scan_start.found && w_start_pat.valid) begin
            w_nxt_state = ST_MARK;
            w_nxt_nib   = w_scan_start.idx;
            w_nxt_elem  = '0;
            w_nxt_pat   = w_start_pat.pat;
            w_nxt_chr   = w_start_nib;
            w_load      = 1'b1;
            w_units     = w_start_pat.pat[4] ? 2'(DASH_UNITS) : 2'(DOT_UNITS);
          end else begin
            w_nxt_state = ST_FINISH;
          end
        end
      end
      ST_MARK: begin
        if (w_expire) begin
          if (r_elem != 3'(ELEMS - 1)) begin
            w_nxt_state = ST_GAP;
            w_nxt_elem  = r_elem + 3'd1;
            w_load      = 1'b1;
            w_units     = 2'(GAP_UNITS);
          end else begin
            w_nxt_bad = r_bad | w_scan_next.bad;
            if (w_scan_next.found && w_next_pat.valid) begin
              w_nxt_state = ST_CHARGAP;
              w_nxt_nib   = w_scan_next.idx;
              w_nxt_pat   = w_next_pat.pat;
              w_load      = 1'b1;
              w_units     = 2'(CHARGAP_UNITS);
            end else begin
              w_nxt_state = ST_FINISH;
            end
          end
        end
      end
      ST_GAP: begin
        if (w_expire) begin
          w_nxt_state = ST_MARK;
          w_load      = 1'b1;
          w_units     = r_pat[3'd4 - r_elem] ? 2'(DASH_UNITS) : 2'(DOT_UNITS);
        end
      end
      ST_CHARGAP: begin
        if (w_expire) begin
          w_nxt_state = ST_MARK;
          w_nxt_elem  = '0;
          w_nxt_chr   = w_cur_nib;
          w_load      = 1'b1;
          w_units     = r_pat[4] ? 2'(DASH_UNITS) : 2'(DOT_UNITS);
        end
      end
      ST_FINISH: w_nxt_state = ST_IDLE;
      default:   w_nxt_state = ST_IDLE;
    endcase
    if (w_clr) begin
      w_nxt_state = ST_IDLE;
      w_load      = 1'b0;
      w_nxt_bad   = isAble ? r_bad : 1'b0;
    end
  end

  // Registered outputs follow the state one cycle later; a clear drops them immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cur_digit <= 4'h0;
    end else if (w_clr) begin
      tone      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cur_digit <= 4'h0;
    end else begin
      tone      <= (r_state == ST_MARK);
      busy      <= w_playing;
      done      <= (r_state == ST_FINISH);
      cur_digit <= w_playing ? r_chr : 4'h0;
    end
  end

endmodule

// File: tb/tb_morse_digit_player.sv
// Bench for morse_digit_player: vector table + run scoreboard, plus abort/enable sequences.
module tb_morse_digit_player;

  localparam int U       = 4;
  localparam int MAX_CYC = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        isAble;
  logic        start;
  logic        abort;
  logic [31:0] digits;
  logic        tone;
  logic        busy;
  logic        done;
  logic [3:0]  cur_digit;
  logic        bad_digit;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic       lvl;
    int         len;
    logic [3:0] code;
  } run_t;

  typedef struct {
    logic [31:0] digits;
    logic        exp_bad;
  } vec_t;

  run_t exp_q[$];

  morse_digit_player #(.UNIT_CYCLES(U)) dut (
    .clk      (clk),
    .rst      (rst),
    .isAble   (isAble),
    .start    (start),
    .abort    (abort),
    .digits   (digits),
    .tone     (tone),
    .busy     (busy),
    .done     (done),
    .cur_digit(cur_digit),
    .bad_digit(bad_digit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic push_run(input logic lvl, input int len, input logic [3:0] code);
    run_t r;
    r.lvl  = lvl;
    r.len  = len;
    r.code = code;
    exp_q.push_back(r);
  endtask

  // Expected tone runs as seen from the first sample after start; first low run is the latency cycle.
  task automatic build_expect(input logic [31:0] d, output bit empty);
    logic [3:0] n;
    bit         first;
    bit         dash;
    exp_q.delete();
    first = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      n = d[4*i +: 4];
      if (n == 4'h0 || n > 4'hA) continue;
      push_run(1'b0, first ? 1 : 3 * U, 4'h0);
      first = 1'b0;
      for (int e = 0; e < 5; e++) begin
        if (n == 4'hA)      dash = 1'b1;
        else if (n <= 4'h5) dash = (e >= int'(n));
        else                dash = (e < int'(n) - 5);
        if (e > 0) push_run(1'b0, U, 4'h0);
        push_run(1'b1, dash ? 3 * U : U, n);
      end
    end
    empty = first;
  endtask

  task automatic close_run(input logic lvl, input int len, input logic [3:0] code);
    run_t e;
    if (exp_q.size() == 0) begin
      fail("extra_run");
    end else begin
      e = exp_q.pop_front();
      chk("run_level", 32'(lvl), 32'(e.lvl));
      chk("run_len", 32'(len), 32'(e.len));
      if (lvl) chk("run_code", 32'(code), 32'(e.code));
    end
  endtask

  // Start playback of d, compare every tone run against the model, then check done/bad_digit.
  task automatic run_vec(input logic [31:0] d, input logic exp_bad);
    bit         empty, got_done, seen_rise;
    logic       cur_lvl;
    int         run_len, busy_err, low_at_done;
    logic [3:0] run_code;
    build_expect(d, empty);
    digits = d;
    start  = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    digits      = 32'hBBBB_9999;
    got_done    = 1'b0;
    seen_rise   = 1'b0;
    cur_lvl     = 1'b0;
    run_len     = 0;
    run_code    = 4'h0;
    busy_err    = 0;
    low_at_done = -1;
    for (int c = 0; c < MAX_CYC && !got_done; c++) begin
      if (c > 0) @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        chk("done_tone", 32'(tone), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_cur", 32'(cur_digit), 32'd0);
        if (cur_lvl) begin
          close_run(1'b1, run_len, run_code);
          low_at_done = 0;
        end else begin
          low_at_done = run_len;
        end
      end else begin
        if (tone) seen_rise = 1'b1;
        if (busy !== seen_rise) busy_err++;
        if (tone !== cur_lvl) begin
          close_run(cur_lvl, run_len, run_code);
          cur_lvl  = tone;
          run_len  = 1;
          run_code = cur_digit;
        end else begin
          run_len++;
        end
      end
      // a start while busy must be ignored
      start = (c == 20) && !got_done;
    end
    start = 1'b0;
    if (!got_done) begin
      fail("done_timeout");
    end else begin
      chk("low_before_done", 32'(low_at_done), empty ? 32'd1 : 32'd0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
    end
    chk("busy_track", 32'(busy_err), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("bad_digit", 32'(bad_digit), 32'(exp_bad));
    @(negedge clk);
  endtask

  initial begin
    vec_t vecs[9];
    int   quiet;

    vecs[0] = '{32'h0000_0001, 1'b0};
    vecs[1] = '{32'h0000_0012, 1'b0};
    vecs[2] = '{32'h0000_000A, 1'b0};
    vecs[3] = '{32'h0000_0000, 1'b0};
    vecs[4] = '{32'h0000_01F6, 1'b1};
    vecs[5] = '{32'h0000_0001, 1'b0};
    vecs[6] = '{32'h0A00_0030, 1'b0};
    vecs[7] = '{32'hC000_0007, 1'b1};
    vecs[8] = '{32'h0000_000F, 1'b1};

    rst    = 1'b1;
    isAble = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    digits = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_tone", 32'(tone), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cur", 32'(cur_digit), 32'd0);
    chk("rst_bad", 32'(bad_digit), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 9; v++) run_vec(vecs[v].digits, vecs[v].exp_bad);

    // abort in idle leaves bad_digit set
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    chk("abort_keeps_bad", 32'(bad_digit), 32'd1);

    // start and abort together: nothing plays and bad_digit is untouched
    digits = 32'h0000_0005;
    start  = 1'b1;
    abort  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    quiet = 0;
    repeat (30) begin
      @(negedge clk);
      if (tone || busy || done || cur_digit != 4'h0) quiet++;
    end
    chk("start_abort_quiet", 32'(quiet), 32'd0);
    chk("start_abort_bad", 32'(bad_digit), 32'd1);

    // mid-dash abort of "12": dot 1..4, gap 5..8, first dash 9..20
    digits = 32'h0000_0012;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_abort_tone", 32'(tone), 32'd1);
    chk("pre_abort_cur", 32'(cur_digit), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_tone", 32'(tone), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cur", 32'(cur_digit), 32'd0);
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      if (tone || busy || done) quiet++;
    end
    chk("abort_quiet", 32'(quiet), 32'd0);
    run_vec(32'h0000_0012, 1'b0);

    // enable drop mid-playback clears everything including bad_digit
    digits = 32'h0000_00F3;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_dis_bad", 32'(bad_digit), 32'd1);
    chk("pre_dis_busy", 32'(busy), 32'd1);
    isAble = 1'b0;
    @(negedge clk);
    isAble = 1'b1;
    chk("dis_tone", 32'(tone), 32'd0);
    chk("dis_busy", 32'(busy), 32'd0);
    chk("dis_bad", 32'(bad_digit), 32'd0);
    quiet = 0;
    repeat (30) begin
      @(negedge clk);
      if (tone || busy || done) quiet++;
    end
    chk("dis_quiet", 32'(quiet), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
